// File: rtl/coproc_ctrl_pkg.sv
// Shared state encoding and error codes for the coprocessor sequence controller.
package coproc_ctrl_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned ERR_W   = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_RUN  = 3'd1;
    localparam logic [STATE_W-1:0] ST_SYNC = 3'd2;
    localparam logic [STATE_W-1:0] ST_SHOW = 3'd3;
    localparam logic [STATE_W-1:0] ST_ERR  = 3'd4;

    localparam logic [ERR_W-1:0] ERR_NONE       = 2'd0;
    localparam logic [ERR_W-1:0] ERR_ILLEGAL_OP = 2'd1;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT    = 2'd2;

endpackage

// File: rtl/coproc_timeout_cnt.sv
// RUN-duration counter with synchronous clear, count enable and a terminal-count
// flag that fires on the last cycle allowed before a timeout.
module coproc_timeout_cnt #(
    parameter int unsigned CNT_W          = 20,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over enable so a fresh launch always starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/coproc_seq_ctrl.sv
// Sequences one coprocessor operation: launch, completion/timeout watch, cycle
// count capture, and a tear-free ROM-to-RAM display switch on a frame boundary.
module coproc_seq_ctrl
    import coproc_ctrl_pkg::*;
#(
    parameter int unsigned NUM_OPS        = 4,
    parameter int unsigned OP_W           = 2,
    parameter int unsigned CNT_W          = 20,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned SYNC_ON_VSYNC  = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [OP_W-1:0]  OP_SEL,
    input  logic             ABORT,
    input  logic             PROC_DONE,
    input  logic             VSYNC,
    output logic             PROC_ENABLE,
    output logic [OP_W-1:0]  PROC_OP,
    output logic             VGA_SOURCE_SELECT,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERROR,
    output logic [ERR_W-1:0] ERR_CODE,
    output logic [CNT_W-1:0] CYCLE_COUNT
);

    logic [STATE_W-1:0] state_q, state_d;
    logic               start_q;
    logic [OP_W-1:0]    op_q, op_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;

    logic               start_pulse;
    logic               op_legal;
    logic               cnt_clr;
    logic               cnt_en;
    logic               cnt_tc;
    logic [CNT_W-1:0]   cnt;

    assign start_pulse = START & ~start_q;
    assign op_legal    = (32'(OP_SEL) < NUM_OPS);

    coproc_timeout_cnt #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .CLK   (CLK),
        .RESET (RESET),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (cnt),
        .tc_o  (cnt_tc)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            op_q    <= '0;
            err_q   <= ERR_NONE;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= START;
            op_q    <= op_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
        end
    end

    // Next state plus the registered side effects of each transition.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        err_d   = err_q;
        cyc_d   = cyc_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_pulse) begin
                    op_d    = OP_SEL;
                    cnt_clr = 1'b1;
                    if (op_legal) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = ERR_ILLEGAL_OP;
                    end
                end
            end
            ST_RUN: begin
                cnt_en = 1'b1;
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else if (PROC_DONE) begin
                    cyc_d   = cnt + CNT_W'(1);
                    state_d = (SYNC_ON_VSYNC != 0) ? ST_SYNC : ST_SHOW;
                end else if (cnt_tc) begin
                    state_d = ST_ERR;
                    err_d   = ERR_TIMEOUT;
                end
            end
            ST_SYNC: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else if (VSYNC) begin
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (start_pulse || ABORT) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (start_pulse || ABORT) begin
                    state_d = ST_IDLE;
                    err_d   = ERR_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                err_d   = ERR_NONE;
            end
        endcase
    end

    // Control outputs decode the state register directly so reset drops them at once.
    always_comb begin
        PROC_ENABLE       = 1'b0;
        VGA_SOURCE_SELECT = 1'b0;
        BUSY              = 1'b0;
        DONE              = 1'b0;
        ERROR             = 1'b0;
        case (state_q)
            ST_RUN: begin
                PROC_ENABLE = 1'b1;
                BUSY        = 1'b1;
            end
            ST_SYNC: begin
                BUSY = 1'b1;
            end
            ST_SHOW: begin
                VGA_SOURCE_SELECT = 1'b1;
                DONE              = 1'b1;
            end
            ST_ERR: begin
                ERROR = 1'b1;
            end
            default: begin
                PROC_ENABLE = 1'b0;
            end
        endcase
    end

    assign PROC_OP     = op_q;
    assign ERR_CODE    = err_q;
    assign CYCLE_COUNT = cyc_q;

endmodule

// File: tb/tb_coproc_seq_ctrl.sv
// Directed walk through launch, sync, error, timeout, abort and reset scenarios,
// followed by random traffic, all compared against a behavioural model.
module tb_coproc_seq_ctrl;

    localparam int unsigned NUM_OPS = 5;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned CNT_W   = 12;
    localparam int unsigned TIMEOUT = 64;

    logic             CLK       = 1'b0;
    logic             RESET     = 1'b1;
    logic             START     = 1'b0;
    logic [OP_W-1:0]  OP_SEL    = '0;
    logic             ABORT     = 1'b0;
    logic             PROC_DONE = 1'b0;
    logic             VSYNC     = 1'b0;
    logic             PROC_ENABLE;
    logic [OP_W-1:0]  PROC_OP;
    logic             VGA_SOURCE_SELECT;
    logic             BUSY;
    logic             DONE;
    logic             ERROR;
    logic [1:0]       ERR_CODE;
    logic [CNT_W-1:0] CYCLE_COUNT;

    int vectors     = 0;
    int miscompares = 0;

    coproc_seq_ctrl #(
        .NUM_OPS        (NUM_OPS),
        .OP_W           (OP_W),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT),
        .SYNC_ON_VSYNC  (1)
    ) dut (
        .CLK               (CLK),
        .RESET             (RESET),
        .START             (START),
        .OP_SEL            (OP_SEL),
        .ABORT             (ABORT),
        .PROC_DONE         (PROC_DONE),
        .VSYNC             (VSYNC),
        .PROC_ENABLE       (PROC_ENABLE),
        .PROC_OP           (PROC_OP),
        .VGA_SOURCE_SELECT (VGA_SOURCE_SELECT),
        .BUSY              (BUSY),
        .DONE              (DONE),
        .ERROR             (ERROR),
        .ERR_CODE          (ERR_CODE),
        .CYCLE_COUNT       (CYCLE_COUNT)
    );

    always #5 CLK = ~CLK;

    // Behavioural model: what the controller is doing, in plain terms.
    typedef enum {M_IDLE, M_WORKING, M_WAIT_FRAME, M_SHOWING, M_FAULT} mode_t;
    mode_t mode;
    bit    prev_start;
    int    m_op;
    int    run_len;
    int    last_len;
    int    m_err;

    task automatic model_reset();
        mode       = M_IDLE;
        prev_start = 1'b0;
        m_op       = 0;
        run_len    = 0;
        last_len   = 0;
        m_err      = 0;
    endtask

    task automatic model_edge();
        bit pulse;
        if (RESET) begin
            model_reset();
            return;
        end
        pulse      = START && !prev_start;
        prev_start = START;
        case (mode)
            M_IDLE: if (pulse) begin
                m_op    = int'(OP_SEL);
                run_len = 0;
                if (int'(OP_SEL) < int'(NUM_OPS)) mode = M_WORKING;
                else begin
                    mode  = M_FAULT;
                    m_err = 1;
                end
            end
            M_WORKING: begin
                run_len++;
                if (ABORT) mode = M_IDLE;
                else if (PROC_DONE) begin
                    last_len = run_len;
                    mode     = M_WAIT_FRAME;
                end else if (run_len == int'(TIMEOUT)) begin
                    mode  = M_FAULT;
                    m_err = 2;
                end
            end
            M_WAIT_FRAME: begin
                if (ABORT) mode = M_IDLE;
                else if (VSYNC) mode = M_SHOWING;
            end
            M_SHOWING: if (pulse || ABORT) mode = M_IDLE;
            M_FAULT: if (pulse || ABORT) begin
                mode  = M_IDLE;
                m_err = 0;
            end
            default: mode = M_IDLE;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("proc_enable", 32'(PROC_ENABLE), 32'(mode == M_WORKING));
        chk("proc_op", 32'(PROC_OP), 32'(m_op));
        chk("vga_sel", 32'(VGA_SOURCE_SELECT), 32'(mode == M_SHOWING));
        chk("busy", 32'(BUSY), 32'(mode == M_WORKING || mode == M_WAIT_FRAME));
        chk("done", 32'(DONE), 32'(mode == M_SHOWING));
        chk("error", 32'(ERROR), 32'(mode == M_FAULT));
        chk("err_code", 32'(ERR_CODE), 32'(m_err));
        chk("cycle_count", 32'(CYCLE_COUNT), 32'(last_len));
    endtask

    task automatic cyc();
        @(posedge CLK);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        #2;
        check_all();
        cyc();
        cyc();
        RESET = 1'b0;

        // Normal launch with START held high for ~100 cycles: one operation only.
        START  = 1'b1;
        OP_SEL = 3'd2;
        cyc();
        chk("launch_enable", 32'(PROC_ENABLE), 32'd1);
        chk("launch_op", 32'(PROC_OP), 32'd2);
        repeat (49) cyc();
        PROC_DONE = 1'b1;
        cyc();
        PROC_DONE = 1'b0;
        chk("cycle_count_50", 32'(CYCLE_COUNT), 32'd50);
        repeat (3) cyc();
        chk("sync_busy", 32'(BUSY), 32'd1);
        chk("sync_vga_rom", 32'(VGA_SOURCE_SELECT), 32'd0);
        VSYNC = 1'b1;
        cyc();
        VSYNC = 1'b0;
        chk("show_vga_ram", 32'(VGA_SOURCE_SELECT), 32'd1);
        repeat (45) cyc();
        chk("held_start_single", 32'(DONE), 32'd1);
        OP_SEL = 3'd7;
        START  = 1'b0;
        cyc();
        START = 1'b1;
        cyc();
        chk("show_exit_op_kept", 32'(PROC_OP), 32'd2);

        // First illegal op value, then recovery on the next START edge.
        START = 1'b0;
        cyc();
        OP_SEL = 3'd5;
        START  = 1'b1;
        cyc();
        chk("illegal_err_code", 32'(ERR_CODE), 32'd1);
        repeat (5) cyc();
        START = 1'b0;
        cyc();
        START = 1'b1;
        cyc();
        chk("illegal_cleared", 32'(ERR_CODE), 32'd0);

        // Timeout after exactly TIMEOUT RUN cycles.
        START = 1'b0;
        cyc();
        OP_SEL = 3'd1;
        START  = 1'b1;
        cyc();
        repeat (TIMEOUT - 1) cyc();
        chk("pre_timeout_busy", 32'(BUSY), 32'd1);
        cyc();
        chk("timeout_code", 32'(ERR_CODE), 32'd2);
        ABORT = 1'b1;
        cyc();
        ABORT = 1'b0;

        // Completion on the terminal cycle beats the timeout.
        START = 1'b0;
        cyc();
        OP_SEL = 3'd3;
        START  = 1'b1;
        cyc();
        repeat (TIMEOUT - 1) cyc();
        PROC_DONE = 1'b1;
        cyc();
        PROC_DONE = 1'b0;
        chk("done_at_limit_no_err", 32'(ERROR), 32'd0);
        chk("done_at_limit_count", 32'(CYCLE_COUNT), 32'(TIMEOUT));

        // Abort in SYNC, then in RUN; captured count must survive.
        ABORT = 1'b1;
        cyc();
        ABORT = 1'b0;
        chk("abort_sync_vga", 32'(VGA_SOURCE_SELECT), 32'd0);
        START = 1'b0;
        cyc();
        OP_SEL = 3'd0;
        START  = 1'b1;
        cyc();
        repeat (5) cyc();
        ABORT = 1'b1;
        cyc();
        ABORT = 1'b0;
        chk("abort_run_count_kept", 32'(CYCLE_COUNT), 32'(TIMEOUT));

        // VSYNC coincident with PROC_DONE is ignored.
        START = 1'b0;
        cyc();
        START = 1'b1;
        cyc();
        repeat (9) cyc();
        PROC_DONE = 1'b1;
        VSYNC     = 1'b1;
        cyc();
        PROC_DONE = 1'b0;
        VSYNC     = 1'b0;
        chk("coincident_vsync_wait", 32'(DONE), 32'd0);
        chk("coincident_count", 32'(CYCLE_COUNT), 32'd10);
        repeat (2) cyc();
        VSYNC = 1'b1;
        cyc();
        VSYNC = 1'b0;
        chk("next_vsync_show", 32'(DONE), 32'd1);
        ABORT = 1'b1;
        cyc();
        ABORT = 1'b0;

        // Asynchronous reset in the middle of RUN.
        START = 1'b0;
        cyc();
        OP_SEL = 3'd3;
        START  = 1'b1;
        cyc();
        repeat (7) cyc();
        #2 RESET = 1'b1;
        #1;
        chk("async_rst_enable", 32'(PROC_ENABLE), 32'd0);
        chk("async_rst_busy", 32'(BUSY), 32'd0);
        chk("async_rst_count", 32'(CYCLE_COUNT), 32'd0);
        chk("async_rst_op", 32'(PROC_OP), 32'd0);
        model_reset();
        check_all();
        cyc();
        cyc();
        RESET = 1'b0;
        START = 1'b0;
        cyc();
        OP_SEL = 3'd4;
        START  = 1'b1;
        cyc();
        chk("post_rst_launch", 32'(PROC_ENABLE), 32'd1);
        chk("post_rst_op4", 32'(PROC_OP), 32'd4);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) START = ~START;
            OP_SEL    = OP_W'($urandom_range(0, 7));
            ABORT     = ($urandom_range(0, 63) == 0);
            PROC_DONE = ($urandom_range(0, 19) == 0);
            VSYNC     = ($urandom_range(0, 7) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
